// File: rtl/cme_ip_fifo_ahb.sv
// cme_ip_fifo_ahb: AHB-Lite slave fronting a 512x32 first-word-fall-through
// FIFO with a small control/status register window. Zero wait states, always
// OKAY. Address-phase controls are registered and acted on in the data phase.
module cme_ip_fifo_ahb #(
    parameter logic [31:0]           BASE_ADDR      = 32'hA000_0000,
    parameter int                    ADDR_WIDTH     = 9,
    parameter logic [ADDR_WIDTH-1:0] PROG_FULL_RST  = 9'd496,
    parameter logic [ADDR_WIDTH-1:0] PROG_EMPTY_RST = 9'd16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready_out,
    output logic        hresp,
    output logic        ahb_fifo_int
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_AFULL = CNT_FULL - {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    localparam logic [7:0] OFF_DATA   = 8'h00;
    localparam logic [7:0] OFF_PF_THR = 8'h04;
    localparam logic [7:0] OFF_PE_THR = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h28;
    localparam logic [7:0] OFF_COUNT  = 8'h2C;

    // Data-phase copy of the address-phase controls.
    logic                  dp_valid;
    logic                  dp_write;
    logic                  dp_burst;
    logic [7:0]            dp_offset;

    // FIFO storage and pointers (one extra bit so full/empty are distinct).
    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH:0]   count;

    // Programmable state.
    logic [ADDR_WIDTH-1:0] pf_thr;
    logic [ADDR_WIDTH-1:0] pe_thr;
    logic                  int_en;
    logic                  overflow;
    logic                  underflow;

    // Derived status.
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  prog_full;
    logic                  prog_empty;
    logic [7:0]            status;

    // Data-phase decode.
    logic                  is_data;
    logic                  wr_data;
    logic                  rd_data;
    logic                  wr_reg;
    logic                  do_push;
    logic                  do_pop;
    logic                  clr;
    logic                  w1c;

    // Upper address bits are decoded by the fabric (hsel); size is fixed at 32 bits.
    logic                  unused_bits;
    assign unused_bits = ^{hsize, htrans[0], haddr[31:8], BASE_ADDR[0]};

    assign hready_out = 1'b1;
    assign hresp      = 1'b0;

    assign count        = wptr - rptr;
    assign empty        = (count == {(ADDR_WIDTH+1){1'b0}});
    assign full         = (count == CNT_FULL);
    assign almost_empty = (count <= CNT_ONE);
    assign almost_full  = (count >= CNT_AFULL);
    assign prog_full    = (count >= {1'b0, pf_thr});
    assign prog_empty   = (count <= {1'b0, pe_thr});
    assign status       = {underflow, overflow, prog_full, prog_empty,
                           almost_full, almost_empty, full, empty};

    // Bursts always stream through DATA; single transfers decode by offset.
    assign is_data = dp_valid & (dp_burst | (dp_offset == OFF_DATA));
    assign wr_data = is_data & dp_write;
    assign rd_data = is_data & ~dp_write;
    assign wr_reg  = dp_valid & dp_write & ~dp_burst;
    assign do_push = wr_data & ~full;
    assign do_pop  = rd_data & ~empty;
    assign clr     = wr_reg & (dp_offset == OFF_CTRL) & hwdata[0];
    assign w1c     = wr_reg & (dp_offset == OFF_STATUS);

    assign ahb_fifo_int = int_en & (prog_full | overflow | underflow);

    // Capture address-phase controls of a valid transfer for its data phase.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_burst  <= 1'b0;
            dp_offset <= 8'h00;
        end else begin
            dp_valid  <= hsel & htrans[1];
            dp_write  <= hwrite;
            dp_burst  <= (hburst != 3'd0);
            dp_offset <= haddr[7:0];
        end
    end

    // FIFO pointer update; clear has priority over any transfer.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wptr <= {(ADDR_WIDTH+1){1'b0}};
            rptr <= {(ADDR_WIDTH+1){1'b0}};
        end else if (clr) begin
            wptr <= {(ADDR_WIDTH+1){1'b0}};
            rptr <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            if (do_push) begin
                wptr <= wptr + CNT_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + CNT_ONE;
            end
        end
    end

    // FIFO storage write; data is unreset since pointers qualify it.
    always_ff @(posedge hclk) begin
        if (do_push) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= hwdata;
        end
    end

    // Threshold and control registers.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            pf_thr <= PROG_FULL_RST;
            pe_thr <= PROG_EMPTY_RST;
            int_en <= 1'b0;
        end else if (wr_reg) begin
            case (dp_offset)
                OFF_PF_THR: pf_thr <= hwdata[ADDR_WIDTH-1:0];
                OFF_PE_THR: pe_thr <= hwdata[ADDR_WIDTH-1:0];
                OFF_CTRL:   int_en <= hwdata[1];
                default:    ;
            endcase
        end else begin
            pf_thr <= pf_thr;
        end
    end

    // Sticky overflow/underflow: set on bad access, cleared by W1C or FIFO clear.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (w1c) begin
            if (hwdata[6]) begin
                overflow <= 1'b0;
            end
            if (hwdata[7]) begin
                underflow <= 1'b0;
            end
        end else begin
            if (wr_data && full) begin
                overflow <= 1'b1;
            end
            if (rd_data && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Read mux for the data phase; FIFO head is shown fall-through.
    always_comb begin
        hrdata = 32'd0;
        if (dp_valid && !dp_write) begin
            if (dp_burst) begin
                hrdata = empty ? 32'd0 : mem[rptr[ADDR_WIDTH-1:0]];
            end else begin
                case (dp_offset)
                    OFF_DATA:   hrdata = empty ? 32'd0 : mem[rptr[ADDR_WIDTH-1:0]];
                    OFF_PF_THR: hrdata = {{(32-ADDR_WIDTH){1'b0}}, pf_thr};
                    OFF_PE_THR: hrdata = {{(32-ADDR_WIDTH){1'b0}}, pe_thr};
                    OFF_CTRL:   hrdata = {30'd0, int_en, 1'b0};
                    OFF_STATUS: hrdata = {24'd0, status};
                    OFF_COUNT:  hrdata = {{(31-ADDR_WIDTH){1'b0}}, count};
                    default:    hrdata = 32'd0;
                endcase
            end
        end else begin
            hrdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_cme_ip_fifo_ahb.sv
// Randomized scoreboard bench for cme_ip_fifo_ahb. The driver updates a
// queue-based FIFO model and pushes expected read data; a monitor compares
// hrdata on every read data phase.
module tb_cme_ip_fifo_ahb;

    localparam logic [31:0] BASE = 32'hA000_0000;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready_out;
    logic        hresp;
    logic        ahb_fifo_int;

    cme_ip_fifo_ahb dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hrdata(hrdata), .hready_out(hready_out),
        .hresp(hresp), .ahb_fifo_int(ahb_fifo_int)
    );

    always #5 hclk = ~hclk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    logic [31:0] model_q[$];
    logic [8:0]  m_pf;
    logic [8:0]  m_pe;
    bit          m_ie;
    bit          m_ovf;
    bit          m_unf;

    // Scoreboard.
    logic [31:0] exp_q[$];
    string       name_q[$];

    // Pending write data for the data phase of the previous beat.
    bit          pend_w;
    logic [31:0] pend_d;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int c = model_q.size();
        logic [7:0] s;
        s[0] = (c == 0);
        s[1] = (c == 512);
        s[2] = (c <= 1);
        s[3] = (c >= 511);
        s[4] = (c <= int'(m_pe));
        s[5] = (c >= int'(m_pf));
        s[6] = m_ovf;
        s[7] = m_unf;
        return {24'd0, s};
    endfunction

    function automatic bit m_int();
        return m_ie & ((model_q.size() >= int'(m_pf)) | m_ovf | m_unf);
    endfunction

    task automatic model_reset();
        model_q.delete();
        m_pf  = 9'd496;
        m_pe  = 9'd16;
        m_ie  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Apply one transfer to the model; reads push their expected data.
    task automatic model_access(logic [7:0] off, bit wr, logic [31:0] wd, string nm);
        logic [31:0] e;
        if (wr) begin
            case (off)
                8'h00: if (model_q.size() == 512) m_ovf = 1'b1; else model_q.push_back(wd);
                8'h04: m_pf = wd[8:0];
                8'h08: m_pe = wd[8:0];
                8'h0C: begin
                    m_ie = wd[1];
                    if (wd[0]) begin
                        model_q.delete();
                        m_ovf = 1'b0;
                        m_unf = 1'b0;
                    end
                end
                8'h28: begin
                    if (wd[6]) m_ovf = 1'b0;
                    if (wd[7]) m_unf = 1'b0;
                end
                default: ;
            endcase
        end else begin
            case (off)
                8'h00: begin
                    if (model_q.size() == 0) begin
                        m_unf = 1'b1;
                        e = 32'd0;
                    end else begin
                        e = model_q.pop_front();
                    end
                end
                8'h04:   e = {23'd0, m_pf};
                8'h08:   e = {23'd0, m_pe};
                8'h0C:   e = {30'd0, m_ie, 1'b0};
                8'h28:   e = m_status();
                8'h2C:   e = model_q.size();
                default: e = 32'd0;
            endcase
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    // Drive one address phase (and the previous beat's write data).
    task automatic drive(logic [31:0] addr, bit wr, logic [31:0] wd, logic [1:0] tr, logic [2:0] bu);
        @(posedge hclk);
        #1;
        hwdata = pend_w ? pend_d : 32'd0;
        hsel   = 1'b1;
        haddr  = addr;
        hwrite = wr;
        htrans = tr;
        hburst = bu;
        pend_w = wr & tr[1];
        pend_d = wd;
    endtask

    task automatic idle();
        @(posedge hclk);
        #1;
        hwdata = pend_w ? pend_d : 32'd0;
        hsel   = 1'b0;
        htrans = 2'd0;
        hwrite = 1'b0;
        hburst = 3'd0;
        pend_w = 1'b0;
    endtask

    task automatic single(logic [7:0] off, bit wr, logic [31:0] wd, string nm);
        model_access(off, wr, wd, nm);
        drive(BASE + {24'd0, off}, wr, wd, 2'd2, 3'd0);
    endtask

    task automatic burst(bit wr, int len, bit wrap);
        logic [2:0]  bu;
        logic [31:0] wd;
        logic [31:0] a;
        case (len)
            4:       bu = wrap ? 3'd2 : 3'd3;
            8:       bu = wrap ? 3'd4 : 3'd5;
            default: bu = wrap ? 3'd6 : 3'd7;
        endcase
        for (int i = 0; i < len; i++) begin
            wd = $urandom;
            a  = BASE + (wrap ? ((i * 4) % (len * 4)) : (i * 4));
            model_access(8'h00, wr, wd, wr ? "burst_wr" : "burst_rd");
            drive(a, wr, wd, (i == 0) ? 2'd2 : 2'd3, bu);
        end
    endtask

    task automatic chk_int(string nm);
        idle();
        idle();
        check(nm, {31'd0, ahb_fifo_int}, {31'd0, m_int()});
    endtask

    // Monitor: track read data phases from the bus and compare hrdata.
    logic dp_rd;
    always @(posedge hclk or posedge hreset) begin
        if (hreset) dp_rd <= 1'b0;
        else        dp_rd <= hsel & htrans[1] & ~hwrite;
    end

    always @(negedge hclk) begin
        if (dp_rd && !hreset) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_read: got %h expected none", hrdata);
            end else begin
                check(name_q.pop_front(), hrdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        int r;
        hreset = 1'b1;
        hsel = 1'b0; haddr = 32'd0; htrans = 2'd0; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hwdata = 32'd0;
        pend_w = 1'b0; pend_d = 32'd0;
        model_reset();
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;

        check("reset_hrdata", hrdata, 32'd0);
        check("reset_int", {31'd0, ahb_fifo_int}, 32'd0);
        check("hready_out", {31'd0, hready_out}, 32'd1);
        check("hresp", {31'd0, hresp}, 32'd0);
        single(8'h28, 1'b0, 32'd0, "reset_status");
        single(8'h2C, 1'b0, 32'd0, "reset_count");

        // Basic single writes and reads.
        single(8'h00, 1'b1, 32'h12345678, "");
        single(8'h00, 1'b1, 32'h23451234, "");
        single(8'h00, 1'b1, 32'h23451122, "");
        single(8'h00, 1'b1, 32'h11221234, "");
        single(8'h04, 1'b1, 32'h00000054, "");
        single(8'h28, 1'b0, 32'd0, "status_4w");
        single(8'h2C, 1'b0, 32'd0, "count_4w");
        for (int i = 0; i < 4; i++) single(8'h00, 1'b0, 32'd0, "data_rd");
        single(8'h04, 1'b0, 32'd0, "pf_thr_rd");

        // Write then immediate read of DATA on an empty FIFO.
        single(8'h00, 1'b1, 32'hCAFEF00D, "");
        single(8'h00, 1'b0, 32'd0, "wr_rd_bypass");

        // Wrapping and incrementing bursts.
        burst(1'b1, 4, 1'b1); burst(1'b1, 8, 1'b1); burst(1'b1, 16, 1'b1);
        single(8'h2C, 1'b0, 32'd0, "count_wrap");
        burst(1'b0, 4, 1'b1); burst(1'b0, 8, 1'b1); burst(1'b0, 16, 1'b1);
        single(8'h2C, 1'b0, 32'd0, "count_wrap_after");
        burst(1'b1, 4, 1'b0); burst(1'b1, 8, 1'b0); burst(1'b1, 16, 1'b0);
        burst(1'b0, 4, 1'b0); burst(1'b0, 8, 1'b0); burst(1'b0, 16, 1'b0);
        single(8'h28, 1'b0, 32'd0, "status_incr");

        // Fill to full, overflow, interrupt and W1C.
        for (int i = 0; i < 512; i++) single(8'h00, 1'b1, $urandom, "");
        single(8'h00, 1'b1, 32'hDEADBEEF, "");
        single(8'h28, 1'b0, 32'd0, "status_full");
        single(8'h2C, 1'b0, 32'd0, "count_full");
        single(8'h0C, 1'b1, 32'h00000002, "");
        chk_int("int_full");
        single(8'h28, 1'b1, 32'h00000040, "");
        single(8'h28, 1'b0, 32'd0, "status_w1c");
        single(8'h0C, 1'b0, 32'd0, "ctrl_rd");

        // Clear, underflow, clear mid-fill.
        single(8'h0C, 1'b1, 32'h00000003, "");
        single(8'h2C, 1'b0, 32'd0, "count_clr");
        single(8'h00, 1'b0, 32'd0, "empty_rd");
        single(8'h28, 1'b0, 32'd0, "status_unf");
        chk_int("int_unf");
        for (int i = 0; i < 10; i++) single(8'h00, 1'b1, $urandom, "");
        single(8'h0C, 1'b1, 32'h00000001, "");
        single(8'h2C, 1'b0, 32'd0, "count_midclr");
        single(8'h28, 1'b0, 32'd0, "status_midclr");
        single(8'h10, 1'b0, 32'd0, "unmapped_rd");

        // Reset during a DATA write data phase: no push.
        idle(); idle();
        drive(BASE, 1'b1, 32'h0BAD0BAD, 2'd2, 3'd0);
        @(posedge hclk);
        #1;
        hwdata = pend_d;
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0;
        hreset = 1'b1;
        pend_w = 1'b0;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        model_reset();
        single(8'h2C, 1'b0, 32'd0, "count_after_rst");
        single(8'h04, 1'b0, 32'd0, "pf_after_rst");
        single(8'h08, 1'b0, 32'd0, "pe_after_rst");

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      single(8'h00, 1'b1, $urandom, "");
            else if (r < 52) single(8'h00, 1'b0, 32'd0, "rnd_data");
            else if (r < 60) burst(1'b1, 4 << $urandom_range(0, 2), $urandom_range(0, 1) == 1);
            else if (r < 67) burst(1'b0, 4 << $urandom_range(0, 2), $urandom_range(0, 1) == 1);
            else if (r < 71) single(8'h04, 1'b1, $urandom, "");
            else if (r < 74) single(8'h08, 1'b1, $urandom, "");
            else if (r < 86) begin
                logic [7:0] offs [7];
                offs = '{8'h04, 8'h08, 8'h0C, 8'h28, 8'h2C, 8'h10, 8'h30};
                single(offs[$urandom_range(0, 6)], 1'b0, 32'd0, "rnd_reg");
            end
            else if (r < 90) single(8'h28, 1'b1, $urandom, "");
            else if (r < 94) single(8'h0C, 1'b1,
                                    {30'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0)}, "");
            else if (r < 97) idle();
            else             chk_int("rnd_int");
        end

        idle(); idle(); idle();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
